// File: rtl/image_readout.sv
// image_readout: streams DST_W*DST_H bytes from a 1-cycle-latency BRAM onto
// a valid/ready byte stream through a 2-entry skid FIFO.
//
// Ports:
//   clk, rst (async, active-high)   start          : frame request (ignored while busy)
//   bram_re, bram_addr              : BRAM read port (bram_rd_data valid next cycle)
//   out_valid/out_data/out_last     : output stream, accepted on out_valid && out_ready
//   busy, done                      : frame in progress / one-cycle completion pulse
// Optional feature: define READER_CHECKSUM_EN to append an 8-bit sum beat.
`timescale 1ns/1ps
module image_readout #(
    parameter int unsigned DST_W     = 16,
    parameter int unsigned DST_H     = 16,
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        bram_re,
    output logic [15:0] bram_addr,
    input  logic [7:0]  bram_rd_data,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_last,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
);

    localparam int unsigned   NPIX     = DST_W * DST_H;
    localparam logic [15:0]   LAST_IDX = 16'(NPIX - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        CSUM
    } state_t;

    state_t      state;
    logic [15:0] cnt;
    logic [7:0]  mem [2];
    logic [1:0]  lst;
    logic        wp;
    logic        rp;
    logic [1:0]  occ;
    logic [1:0]  occ_nxt;
    logic [1:0]  lvl;
    logic        infl;
    logic        infl_last;
    logic        fifo_valid;
    logic        fifo_pop;
`ifdef READER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    // A read may issue whenever the FIFO plus in-flight slot has room,
    // counting a slot being freed by a handshake in this same cycle.
    always_comb begin
        lvl        = occ + {1'b0, infl};
        fifo_valid = (occ != 2'd0);
        fifo_pop   = fifo_valid && out_ready;
        occ_nxt    = occ - {1'b0, fifo_pop} + {1'b0, infl};
        bram_re    = (state == READ) && ((lvl != 2'd2) || fifo_pop);
        bram_addr  = bram_re ? (BASE_ADDR + cnt) : 16'd0;
        out_valid  = fifo_valid;
        out_data   = fifo_valid ? mem[rp] : 8'd0;
        out_last   = fifo_valid && lst[rp];
`ifdef READER_CHECKSUM_EN
        if (state == CSUM) begin
            out_valid = 1'b1;
            out_data  = csum;
            out_last  = 1'b1;
        end
`endif
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (infl) mem[wp] <= bram_rd_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 16'd0;
            lst       <= 2'b00;
            wp        <= 1'b0;
            rp        <= 1'b0;
            occ       <= 2'd0;
            infl      <= 1'b0;
            infl_last <= 1'b0;
            done      <= 1'b0;
`ifdef READER_CHECKSUM_EN
            csum      <= 8'd0;
`endif
        end else begin
            done <= 1'b0;
            infl <= bram_re;
`ifdef READER_CHECKSUM_EN
            infl_last <= 1'b0;
            if (fifo_pop) csum <= csum + out_data;
`else
            infl_last <= bram_re && (cnt == LAST_IDX);
`endif
            if (infl) begin
                lst[wp] <= infl_last;
                wp      <= ~wp;
            end
            if (fifo_pop) rp <= ~rp;
            occ <= occ_nxt;
            if (bram_re) cnt <= cnt + 16'd1;

            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= READ;
                        cnt   <= 16'd0;
`ifdef READER_CHECKSUM_EN
                        csum  <= 8'd0;
`endif
                    end
                end
                READ: begin
                    if (bram_re && (cnt == LAST_IDX)) state <= DRAIN;
                end
                DRAIN: begin
                    // Leave as soon as the final pixel is accepted this edge.
                    if (occ_nxt == 2'd0) begin
`ifdef READER_CHECKSUM_EN
                        state <= CSUM;
`else
                        state <= IDLE;
                        done  <= 1'b1;
`endif
                    end
                end
                CSUM: begin
                    if (out_ready) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_image_readout.sv
// tb_image_readout: directed tests for image_readout.
// Three instances: 4x4 @0x0000, 4x4 @0x0100, 2x2 @0xFFFE.
`timescale 1ns/1ps
module tb_image_readout;

`ifdef READER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic ready;
    int   sel;
    logic [7:0] off;

    always #5 clk = ~clk;

    logic start_a, start_b, start_c;
    logic re_a, re_b, re_c;
    logic [15:0] addr_a, addr_b, addr_c;
    logic [7:0] rd_a, rd_b, rd_c;
    logic valid_a, valid_b, valid_c;
    logic [7:0] data_a, data_b, data_c;
    logic last_a, last_b, last_c;
    logic busy_a, busy_b, busy_c;
    logic done_a, done_b, done_c;

    assign start_a = start && (sel == 0);
    assign start_b = start && (sel == 1);
    assign start_c = start && (sel == 2);

    image_readout #(.DST_W(4), .DST_H(4), .BASE_ADDR(16'h0000)) u_a (
        .clk(clk), .rst(rst), .start(start_a),
        .bram_re(re_a), .bram_addr(addr_a), .bram_rd_data(rd_a),
        .out_valid(valid_a), .out_data(data_a), .out_last(last_a),
        .out_ready(ready), .busy(busy_a), .done(done_a)
    );
    image_readout #(.DST_W(4), .DST_H(4), .BASE_ADDR(16'h0100)) u_b (
        .clk(clk), .rst(rst), .start(start_b),
        .bram_re(re_b), .bram_addr(addr_b), .bram_rd_data(rd_b),
        .out_valid(valid_b), .out_data(data_b), .out_last(last_b),
        .out_ready(ready), .busy(busy_b), .done(done_b)
    );
    image_readout #(.DST_W(2), .DST_H(2), .BASE_ADDR(16'hFFFE)) u_c (
        .clk(clk), .rst(rst), .start(start_c),
        .bram_re(re_c), .bram_addr(addr_c), .bram_rd_data(rd_c),
        .out_valid(valid_c), .out_data(data_c), .out_last(last_c),
        .out_ready(ready), .busy(busy_c), .done(done_c)
    );

    // BRAM models: content is the address low byte plus an offset.
    always @(posedge clk) begin
        if (re_a) rd_a <= addr_a[7:0] + off;
        if (re_b) rd_b <= addr_b[7:0] + off;
        if (re_c) rd_c <= addr_c[7:0] + off;
    end

    logic o_re, o_valid, o_last, o_busy, o_done;
    logic [15:0] o_addr;
    logic [7:0] o_data;

    always_comb begin
        o_re = re_a; o_addr = addr_a; o_valid = valid_a;
        o_data = data_a; o_last = last_a; o_busy = busy_a; o_done = done_a;
        case (sel)
            1: begin
                o_re = re_b; o_addr = addr_b; o_valid = valid_b;
                o_data = data_b; o_last = last_b; o_busy = busy_b; o_done = done_b;
            end
            2: begin
                o_re = re_c; o_addr = addr_c; o_valid = valid_c;
                o_data = data_c; o_last = last_c; o_busy = busy_c; o_done = done_c;
            end
            default: ;
        endcase
    end

    int checks = 0;
    int errors = 0;

    logic [15:0] rd_q[$];
    logic [7:0]  beat_q[$];
    logic        last_q[$];
    logic        bsy_q[$];
    int          done_q[$];
    int          acc_q[$];
    int idx, first_v, outst, max_out, hold_err;
    logic pv, pacc, pl;
    logic [7:0] pd;

    task automatic clear_rec();
        rd_q.delete(); beat_q.delete(); last_q.delete();
        bsy_q.delete(); done_q.delete(); acc_q.delete();
        idx = 0; first_v = -1; outst = 0; max_out = 0; hold_err = 0;
        pv = 1'b0; pacc = 1'b0; pl = 1'b0; pd = 8'd0;
    endtask

    // One clock: drive inputs at negedge, sample 1ns later, log activity.
    task automatic cyc(input logic s, input logic r);
        @(negedge clk);
        start = s;
        ready = r;
        #1;
        if (o_re) begin
            rd_q.push_back(o_addr);
            outst++;
        end
        if (pv && !pacc && (!o_valid || o_data !== pd || o_last !== pl))
            hold_err++;
        if (o_valid && first_v < 0) first_v = idx;
        if (o_valid && r) begin
            beat_q.push_back(o_data);
            last_q.push_back(o_last);
            acc_q.push_back(idx);
            outst--;
        end
        if (outst > max_out) max_out = outst;
        if (o_done) done_q.push_back(idx);
        bsy_q.push_back(o_busy);
        pv = o_valid; pacc = o_valid && r; pd = o_data; pl = o_last;
        idx++;
    endtask

    task automatic run_frames(input int want, input int limit, input bit bp);
        for (int k = 0; k < limit && done_q.size() < want; k++)
            cyc(1'b0, bp ? ((idx % 4 == 0) || (idx % 4 == 3)) : 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; ready = 1'b0; sel = 0; off = 8'd0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({re_a, addr_a, valid_a, data_a, last_a, busy_a, done_a} !== 29'd0) begin
            errors++;
            $display("FAIL reset_a got %h want 0",
                {re_a, addr_a, valid_a, data_a, last_a, busy_a, done_a});
        end
        checks++;
        if ({re_b, addr_b, valid_b, data_b, last_b, busy_b, done_b} !== 29'd0) begin
            errors++;
            $display("FAIL reset_b got %h want 0",
                {re_b, addr_b, valid_b, data_b, last_b, busy_b, done_b});
        end
        checks++;
        if ({re_c, addr_c, valid_c, data_c, last_c, busy_c, done_c} !== 29'd0) begin
            errors++;
            $display("FAIL reset_c got %h want 0",
                {re_c, addr_c, valid_c, data_c, last_c, busy_c, done_c});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_ramp();
        logic [7:0] exp_d;
        sel = 0; off = 8'd0;
        clear_rec();
        cyc(1'b1, 1'b1);
        run_frames(1, 60, 1'b0);
        checks++;
        if (done_q.size() !== 1) begin
            errors++;
            $display("FAIL ramp_done_count got %0d want 1 (timeout?)", done_q.size());
        end
        checks++;
        if (first_v !== 3) begin
            errors++;
            $display("FAIL ramp_first_valid got %0d want 3", first_v);
        end
        checks++;
        if (beat_q.size() !== 16 + CS) begin
            errors++;
            $display("FAIL ramp_beats got %0d want %0d", beat_q.size(), 16 + CS);
        end
        for (int i = 0; i < beat_q.size() && i < 16 + CS; i++) begin
            exp_d = (i < 16) ? 8'(i) : 8'h78;
            checks++;
            if (beat_q[i] !== exp_d || last_q[i] !== (i == 15 + CS)) begin
                errors++;
                $display("FAIL ramp_beat%0d got %h/%b want %h/%b",
                    i, beat_q[i], last_q[i], exp_d, (i == 15 + CS));
            end
        end
        checks++;
        if (rd_q.size() !== 16) begin
            errors++;
            $display("FAIL ramp_reads got %0d want 16", rd_q.size());
        end
        for (int i = 0; i < rd_q.size() && i < 16; i++) begin
            checks++;
            if (rd_q[i] !== 16'(i)) begin
                errors++;
                $display("FAIL ramp_addr%0d got %h want %h", i, rd_q[i], 16'(i));
            end
        end
        if (done_q.size() > 0) begin
            checks++;
            if (done_q[0] !== 19 + CS) begin
                errors++;
                $display("FAIL ramp_done_cycle got %0d want %0d", done_q[0], 19 + CS);
            end
        end
        if (bsy_q.size() > 19 + CS && acc_q.size() > 0) begin
            checks++;
            if ({bsy_q[0], bsy_q[1], bsy_q[18 + CS], bsy_q[19 + CS]} !== 4'b0110) begin
                errors++;
                $display("FAIL ramp_busy got %b want 0110",
                    {bsy_q[0], bsy_q[1], bsy_q[18 + CS], bsy_q[19 + CS]});
            end
            checks++;
            if (acc_q[acc_q.size() - 1] !== 18 + CS) begin
                errors++;
                $display("FAIL ramp_last_accept got %0d want %0d",
                    acc_q[acc_q.size() - 1], 18 + CS);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_d;
        sel = 0; off = 8'd0;
        clear_rec();
        cyc(1'b1, 1'b1);
        run_frames(1, 150, 1'b1);
        checks++;
        if (done_q.size() !== 1) begin
            errors++;
            $display("FAIL bp_done_count got %0d want 1 (timeout?)", done_q.size());
        end
        checks++;
        if (beat_q.size() !== 16 + CS) begin
            errors++;
            $display("FAIL bp_beats got %0d want %0d", beat_q.size(), 16 + CS);
        end
        for (int i = 0; i < beat_q.size() && i < 16 + CS; i++) begin
            exp_d = (i < 16) ? 8'(i) : 8'h78;
            checks++;
            if (beat_q[i] !== exp_d) begin
                errors++;
                $display("FAIL bp_beat%0d got %h want %h", i, beat_q[i], exp_d);
            end
        end
        checks++;
        if (hold_err !== 0) begin
            errors++;
            $display("FAIL bp_hold_stable got %0d violations want 0", hold_err);
        end
        checks++;
        if (max_out > 2) begin
            errors++;
            $display("FAIL bp_outstanding got %0d want <=2", max_out);
        end
        checks++;
        if (rd_q.size() !== 16) begin
            errors++;
            $display("FAIL bp_reads got %0d want 16", rd_q.size());
        end
        for (int i = 0; i < rd_q.size() && i < 16; i++) begin
            checks++;
            if (rd_q[i] !== 16'(i)) begin
                errors++;
                $display("FAIL bp_addr%0d got %h want %h", i, rd_q[i], 16'(i));
            end
        end
    endtask

    task automatic test_reset_mid();
        sel = 0; off = 8'd0;
        clear_rec();
        cyc(1'b1, 1'b1);
        for (int k = 0; k < 40 && beat_q.size() < 5; k++) cyc(1'b0, 1'b1);
        @(posedge clk);
        #2;
        checks++;
        if ({busy_a, valid_a} !== 2'b11) begin
            errors++;
            $display("FAIL rstmid_pre got busy/valid %b want 11", {busy_a, valid_a});
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({re_a, addr_a, valid_a, data_a, last_a, busy_a, done_a} !== 29'd0) begin
            errors++;
            $display("FAIL rstmid_async got %h want 0",
                {re_a, addr_a, valid_a, data_a, last_a, busy_a, done_a});
        end
        @(negedge clk);
        rst = 1'b0;
        clear_rec();
        repeat (4) cyc(1'b0, 1'b1);
        checks++;
        if (beat_q.size() + rd_q.size() !== 0) begin
            errors++;
            $display("FAIL rstmid_no_resume got %0d events want 0",
                beat_q.size() + rd_q.size());
        end
        clear_rec();
        cyc(1'b1, 1'b1);
        run_frames(1, 60, 1'b0);
        checks++;
        if (beat_q.size() !== 16 + CS || done_q.size() !== 1) begin
            errors++;
            $display("FAIL rstmid_replay got %0d beats %0d done want %0d/1",
                beat_q.size(), done_q.size(), 16 + CS);
        end
        if (beat_q.size() > 0 && rd_q.size() > 0) begin
            checks++;
            if ({rd_q[0], beat_q[0]} !== 24'd0) begin
                errors++;
                $display("FAIL rstmid_first got addr %h data %h want 0/0",
                    rd_q[0], beat_q[0]);
            end
        end
    endtask

    task automatic test_ignored_start();
        sel = 0; off = 8'd0;
        clear_rec();
        cyc(1'b1, 1'b1);
        repeat (5) cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        run_frames(1, 60, 1'b0);
        repeat (3) cyc(1'b0, 1'b1);
        checks++;
        if (done_q.size() !== 1 || rd_q.size() !== 16 || beat_q.size() !== 16 + CS) begin
            errors++;
            $display("FAIL ign_counts got done %0d reads %0d beats %0d want 1/16/%0d",
                done_q.size(), rd_q.size(), beat_q.size(), 16 + CS);
        end
        for (int i = 0; i < beat_q.size() && i < 16; i++) begin
            checks++;
            if (beat_q[i] !== 8'(i)) begin
                errors++;
                $display("FAIL ign_beat%0d got %h want %h", i, beat_q[i], 8'(i));
            end
        end
        checks++;
        if (bsy_q[bsy_q.size() - 1] !== 1'b0) begin
            errors++;
            $display("FAIL ign_idle_busy got 1 want 0");
        end
    endtask

    task automatic test_back_to_back();
        sel = 1; off = 8'd0;
        clear_rec();
        cyc(1'b1, 1'b1);
        repeat (18 + CS) cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        checks++;
        if (done_q.size() !== 1 || bsy_q[bsy_q.size() - 1] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done_cycle got done %0d busy %b want 1/0",
                done_q.size(), bsy_q[bsy_q.size() - 1]);
        end
        run_frames(2, 80, 1'b0);
        checks++;
        if (done_q.size() !== 2) begin
            errors++;
            $display("FAIL b2b_done_count got %0d want 2 (timeout?)", done_q.size());
        end else begin
            checks++;
            if (done_q[1] !== 2 * (19 + CS)) begin
                errors++;
                $display("FAIL b2b_done2 got %0d want %0d", done_q[1], 2 * (19 + CS));
            end
        end
        checks++;
        if (rd_q.size() !== 32) begin
            errors++;
            $display("FAIL b2b_reads got %0d want 32", rd_q.size());
        end else begin
            checks++;
            if ({rd_q[0], rd_q[15], rd_q[16], rd_q[31]} !== 64'h0100_010F_0100_010F) begin
                errors++;
                $display("FAIL b2b_addrs got %h %h %h %h want 0100 010f 0100 010f",
                    rd_q[0], rd_q[15], rd_q[16], rd_q[31]);
            end
        end
        checks++;
        if (beat_q.size() !== 2 * (16 + CS)) begin
            errors++;
            $display("FAIL b2b_beats got %0d want %0d", beat_q.size(), 2 * (16 + CS));
        end else begin
            checks++;
            if (beat_q[16 + CS] !== 8'h00 || beat_q[31 + CS] !== 8'h0F) begin
                errors++;
                $display("FAIL b2b_frame2 got %h..%h want 00..0f",
                    beat_q[16 + CS], beat_q[31 + CS]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [15:0] ea [4];
        logic [7:0]  ed [5];
        ea[0] = 16'hFFFE; ea[1] = 16'hFFFF; ea[2] = 16'h0000; ea[3] = 16'h0001;
        ed[0] = 8'hFE; ed[1] = 8'hFF; ed[2] = 8'h00; ed[3] = 8'h01; ed[4] = 8'hFE;
        sel = 2; off = 8'd0;
        clear_rec();
        cyc(1'b1, 1'b1);
        run_frames(1, 40, 1'b0);
        checks++;
        if (rd_q.size() !== 4 || beat_q.size() !== 4 + CS) begin
            errors++;
            $display("FAIL wrap_counts got reads %0d beats %0d want 4/%0d",
                rd_q.size(), beat_q.size(), 4 + CS);
        end
        for (int i = 0; i < rd_q.size() && i < 4; i++) begin
            checks++;
            if (rd_q[i] !== ea[i]) begin
                errors++;
                $display("FAIL wrap_addr%0d got %h want %h", i, rd_q[i], ea[i]);
            end
        end
        for (int i = 0; i < beat_q.size() && i < 4 + CS; i++) begin
            checks++;
            if (beat_q[i] !== ed[i] || last_q[i] !== (i == 3 + CS)) begin
                errors++;
                $display("FAIL wrap_beat%0d got %h/%b want %h/%b",
                    i, beat_q[i], last_q[i], ed[i], (i == 3 + CS));
            end
        end
    endtask

`ifdef READER_CHECKSUM_EN
    task automatic test_checksum();
        sel = 0; off = 8'd240;
        clear_rec();
        cyc(1'b1, 1'b1);
        run_frames(1, 60, 1'b0);
        checks++;
        if (beat_q.size() !== 17) begin
            errors++;
            $display("FAIL csum_beats got %0d want 17", beat_q.size());
        end else begin
            checks++;
            if ({beat_q[0], beat_q[16]} !== 16'hF078) begin
                errors++;
                $display("FAIL csum_value got %h %h want f0 78", beat_q[0], beat_q[16]);
            end
            checks++;
            if ({last_q[15], last_q[16]} !== 2'b01) begin
                errors++;
                $display("FAIL csum_last got %b want 01", {last_q[15], last_q[16]});
            end
        end
        off = 8'd0;
    endtask
`endif

    initial begin
        test_reset();
        test_ramp();
        test_backpressure();
        test_reset_mid();
        test_ignored_start();
        test_back_to_back();
        test_wrap();
`ifdef READER_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
